// File: rtl/sdiv_59x35.sv
// sdiv_59x35: sequential restoring signed divider, one quotient bit per clock, start/valid handshake
module sdiv_59x35 #(
  parameter int DW = 59,
  parameter int VW = 35
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);
  localparam int CW = $clog2(DW);
  localparam logic [1:0] IDLE = 2'd0, ABS = 2'd1, ITER = 2'd2, FIX = 2'd3;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] dq;
  logic [VW-1:0] m, r;
  logic          sa, sb;
  logic [VW:0]   sh;
  logic          neg, dz;
  // dq holds the dividend magnitude and collects quotient bits from the LSB end
  assign sh   = {r, dq[DW-1]};
  assign neg  = sh < {1'b0, m};
  assign dz   = m == '0;
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      dq        <= '0;
      m         <= '0;
      r         <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      valid     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          dq    <= dividend;
          m     <= divisor;
          state <= ABS;
        end
        ABS: begin
          sa    <= dq[DW-1];
          sb    <= m[VW-1];
          dq    <= dq[DW-1] ? -dq : dq;
          m     <= m[VW-1] ? -m : m;
          r     <= '0;
          cnt   <= CW'(DW-1);
          state <= ITER;
        end
        ITER: begin
          r     <= neg ? sh[VW-1:0] : sh[VW-1:0] - m;
          dq    <= {dq[DW-2:0], ~neg};
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : ITER;
        end
        default: begin
          quotient  <= dz ? '0 : (sa ^ sb) ? -dq : dq;
          remainder <= dz ? '0 : sa ? -r : r;
          div_zero  <= dz;
          valid     <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_sdiv_59x35.sv
// tb_sdiv_59x35: directed table, handshake/reset sequences and random checks against a reference model
module tb_sdiv_59x35;
  logic        clk = 0, rstn = 0, start = 0;
  logic [58:0] dividend = '0, quotient;
  logic [34:0] divisor = '0, remainder;
  logic        busy, valid, div_zero;
  int          checks = 0, errors = 0;

  sdiv_59x35 dut (.clk(clk), .rstn(rstn), .start(start), .dividend(dividend), .divisor(divisor),
                  .busy(busy), .valid(valid), .quotient(quotient), .remainder(remainder), .div_zero(div_zero));

  always #5 clk = ~clk;

  typedef struct {
    logic [58:0] a;
    logic [34:0] b;
    logic [58:0] q;
    logic [34:0] r;
    logic        dz;
  } vec_t;
  vec_t tbl[9];

  task automatic check(input string n, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask

  function automatic void ref_div(input logic [58:0] a, input logic [34:0] b,
                                  output logic [58:0] q, output logic [34:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      q = '0;
      r = '0;
    end else begin
      q = 59'(sa / sb);
      r = 35'(sa % sb);
    end
  endfunction

  task automatic do_start(input logic [58:0] a, input logic [34:0] b);
    start = 1; dividend = a; divisor = b;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!valid && lat < 200);
    if (!valid) check("valid timeout", 0, 1);
  endtask

  task automatic check_cycle_after(input string n);
    @(posedge clk);
    #1 check({n, " valid one cycle"}, valid, 0);
  endtask

  task automatic check_zero(input string n);
    check({n, " busy"}, busy, 0);
    check({n, " valid"}, valid, 0);
    check({n, " quotient"}, quotient, 0);
    check({n, " remainder"}, remainder, 0);
    check({n, " div_zero"}, div_zero, 0);
  endtask

  initial begin
    int lat, seen;
    logic [58:0] eq;
    logic [34:0] er;
    logic signed [58:0] ra;
    logic signed [34:0] rb;
    tbl[0] = '{59'd100, 35'd7, 59'd14, 35'd2, 1'b0};
    tbl[1] = '{59'(-100), 35'd7, 59'(-14), 35'(-2), 1'b0};
    tbl[2] = '{59'd100, 35'(-7), 59'(-14), 35'd2, 1'b0};
    tbl[3] = '{59'(-100), 35'(-7), 59'd14, 35'(-2), 1'b0};
    tbl[4] = '{{1'b0, {58{1'b1}}}, 35'd1, {1'b0, {58{1'b1}}}, 35'd0, 1'b0};
    tbl[5] = '{{1'b1, 58'b0}, {35{1'b1}}, {1'b1, 58'b0}, 35'd0, 1'b0};
    tbl[6] = '{59'd5, {1'b0, {34{1'b1}}}, 59'd0, 35'd5, 1'b0};
    tbl[7] = '{59'd1234, 35'd0, 59'd0, 35'd0, 1'b1};
    tbl[8] = '{59'd9, 35'd3, 59'd3, 35'd0, 1'b0};
    #2 check_zero("reset");
    @(negedge clk) rstn = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      do_start(tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d busy", i), busy, 1);
      wait_valid(lat);
      check($sformatf("vec%0d latency", i), lat, 61);
      check($sformatf("vec%0d quotient", i), quotient, tbl[i].q);
      check($sformatf("vec%0d remainder", i), remainder, tbl[i].r);
      check($sformatf("vec%0d div_zero", i), div_zero, tbl[i].dz);
      check($sformatf("vec%0d busy at valid", i), busy, 0);
    end
    check_cycle_after("vec8");
    // start pulsed mid-operation must be dropped
    do_start(59'd100, 35'd7);
    repeat (9) @(posedge clk);
    #1 begin start = 1; dividend = 59'd50; divisor = 35'd5; end
    @(posedge clk);
    #1 start = 0;
    wait_valid(lat);
    check("ignore latency", lat + 10, 61);
    check("ignore quotient", quotient, 14);
    check("ignore remainder", remainder, 2);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1 if (valid) seen++;
    end
    check("ignore no second valid", seen, 0);
    // start in the valid cycle is accepted
    do_start(59'd100, 35'd7);
    wait_valid(lat);
    do_start(59'd50, 35'd5);
    wait_valid(lat);
    check("b2b latency", lat, 61);
    check("b2b quotient", quotient, 10);
    check("b2b remainder", remainder, 0);
    // reset mid-operation
    do_start(59'd100, 35'd7);
    repeat (29) @(posedge clk);
    #1 rstn = 0;
    #1 check_zero("midreset");
    repeat (3) @(posedge clk);
    #1 rstn = 1;
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1 if (valid) seen++;
    end
    check("midreset no valid", seen, 0);
    check("midreset busy", busy, 0);
    do_start(59'd100, 35'd7);
    wait_valid(lat);
    check("post reset latency", lat, 61);
    check("post reset quotient", quotient, 14);
    check("post reset remainder", remainder, 2);
    // random operands against the reference model
    for (int i = 0; i < 800; i++) begin
      ra = 59'({$urandom, $urandom});
      ra = ra >>> $urandom_range(0, 20);
      rb = 35'({$urandom, $urandom});
      rb = rb >>> $urandom_range(0, 34);
      if ($urandom_range(0, 49) == 0) rb = '0;
      ref_div(ra, rb, eq, er);
      do_start(ra, rb);
      wait_valid(lat);
      check($sformatf("rnd%0d latency", i), lat, 61);
      check($sformatf("rnd%0d quotient", i), quotient, eq);
      check($sformatf("rnd%0d remainder", i), remainder, er);
      check($sformatf("rnd%0d div_zero", i), div_zero, rb == 0);
      if (rb != 0)
        check($sformatf("rnd%0d identity", i),
              59'(longint'($signed(quotient)) * longint'(rb) + longint'($signed(remainder))), ra);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
